rx_frame_sched: RTL and testbench
=================================

# rx_frame_sched

Sequences the receive byte stream into a ping-pong frame store. Sits between the RGMII-side nibble receiver (byte, address, cycle outputs) and the frame-buffer RAM. It gates writes, drops malformed or oversized frames, and swaps banks when a full buffer cycle has landed. It hands the completed bank to the consumer with a ready/ack handshake and keeps drop and overflow statistics.

## Interface
- `MAXLEN`, 1500: maximum payload bytes accepted per frame.
- `AW`, 14: address/cycle width.
- `rxclk` in 1: receive clock; all logic on posedge.
- `rst_n` in 1: asynchronous active-low reset.
- `rxctl` in 1: frame active, high for the whole frame.
- `din_vld` in 1: `din`/`din_addr` carry a payload byte this cycle.
- `din` in 8: payload byte.
- `din_addr` in AW: target buffer address of `din`.
- `din_cycle` in AW: buffer cycle length in bytes; stable while `rxctl`=1.
- `frame_ack` in 1: consumer releases the front bank (1-cycle pulse).
- `wr_en` out 1: RAM write strobe.
- `wr_bank` out 1: bank being written (back bank).
- `wr_addr` out AW: RAM address.
- `wr_data` out 8: RAM data.
- `rd_bank` out 1: front bank, always `~wr_bank`.
- `frame_rdy` out 1: front bank holds a complete cycle.
- `drop_cnt` out 16: frames discarded.
- `ovf_cnt` out 16: completed cycles lost because the consumer was busy.

## Operation
- States:
  - IDLE: `rxctl` 1 → RECV (byte count cleared, `err` cleared).
  - RECV:
    - On `din_vld`: if `din_cycle`==0, `din_addr`>=`din_cycle`, or byte count = MAXLEN, set `err` and do not write.
    - Otherwise write and increment the count.
    - If `din_vld` coincides with `rxctl` 0, the byte is still processed.
    - `rxctl` 0 → CHECK.
  - CHECK:
    - `err` set, or count 0 → `drop_cnt`++, go to IDLE. Already-written bytes stay in the back bank; no swap.
    - Else, if the last written address was `din_cycle`-1 → COMMIT.
    - Else → IDLE; the bank keeps accumulating across frames.
  - COMMIT:
    - If `frame_rdy`=0, or `frame_ack`=1 this cycle: toggle `wr_bank` and set `frame_rdy`.
    - Otherwise `ovf_cnt`++ and keep `wr_bank`; the back bank is overwritten by later frames.
    - Always → IDLE.
- A `frame_ack` outside COMMIT clears `frame_rdy` the next cycle. A `frame_ack` while `frame_rdy`=0 is ignored.
- Counters saturate at 16'hFFFF.
- Byte count is 11 bits. The MAXLEN compare is `>=`, so byte MAXLEN+1 is rejected.
- Reset values: state IDLE, `wr_en` 0, `wr_bank` 0, `rd_bank` 1, `wr_addr` 0, `wr_data` 0, `frame_rdy` 0, both counters 0.
- Reset mid-frame abandons the frame without counting it.

## Timing
- `wr_en`/`wr_addr`/`wr_data` are registered, 1 cycle after `din_vld`.
- `rxctl` fall at cycle N: CHECK at N+1, COMMIT at N+2, `wr_bank`/`frame_rdy` update visible at N+3.
- No writes are issued in CHECK or COMMIT. Payload cannot arrive then, because `rxctl` re-rise needs a preamble.
- `frame_ack` to `frame_rdy` low: 1 cycle.
- `frame_ack` and swap in the same cycle: `frame_rdy` stays 1 (new bank).

## Configuration
- `RX_FRAME_SCHED_STAT_EN` defined: `drop_cnt`/`ovf_cnt` counters are implemented.
- Not defined: both outputs are tied to 0 and no counter flops exist. Drop and swap behaviour is unchanged.

## Structure
- Shared package `rx_pkg`:
  - state enum `rx_sched_st_t` (IDLE, RECV, CHECK, COMMIT);
  - `RX_AW` = 14, `RX_MAXLEN` = 1500, `RX_CNT_W` = 16.
- One sub-module, `rx_sat_cnt`: saturating 16-bit counter with inc/clear, instantiated twice under the macro.

## Test plan
- Single good frame: cycle 8, addresses 0..7, consumer idle → 8 writes, bank 0 at addr 0..7, then `wr_bank` 1, `frame_rdy` 1 three cycles after `rxctl` fall.
- Split cycle: cycle 8 delivered as frames of addr 0..3 and 4..7 → no swap after the first, swap after the second, `drop_cnt` 0.
- Out-of-range: cycle 4, frame carries addr 3 then 4 → only addr 3 written, `drop_cnt` 1, no swap.
- Oversize: cycle 2000, 1501 bytes → 1500 writes, `drop_cnt` 1, no swap.
- Overflow: two complete cycles with no `frame_ack` → `ovf_cnt` 1, `wr_bank` toggled once. Then `frame_ack` → `frame_rdy` 0 next cycle.
- Reset mid-frame after 3 writes (`rst_n` low) → all outputs at reset values immediately. Next good frame writes bank 0 from its first byte.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and constants for the receive frame scheduler.
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } rx_sched_st_t;

    localparam int RX_AW     = 14;
    localparam int RX_MAXLEN = 1500;
    localparam int RX_CNT_W  = 16;
    localparam int RX_BCNT_W = 11;

endpackage

// File: rtl/rx_sat_cnt.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module rx_sat_cnt
    import rx_pkg::*;
#(
    parameter int W = RX_CNT_W
) (
    input  logic         rxclk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // counter register: clear wins over increment, stop at the ceiling
    always_ff @(posedge rxclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/rx_frame_sched.sv
// Ping-pong frame store write scheduler with drop/overflow handling.
// Statistics counters are built only when RX_FRAME_SCHED_STAT_EN is defined.
module rx_frame_sched
    import rx_pkg::*;
#(
    parameter int MAXLEN = RX_MAXLEN,
    parameter int AW     = RX_AW
) (
    input  logic                rxclk,
    input  logic                rst_n,
    input  logic                rxctl,
    input  logic                din_vld,
    input  logic [7:0]          din,
    input  logic [AW-1:0]       din_addr,
    input  logic [AW-1:0]       din_cycle,
    input  logic                frame_ack,
    output logic                wr_en,
    output logic                wr_bank,
    output logic [AW-1:0]       wr_addr,
    output logic [7:0]          wr_data,
    output logic                rd_bank,
    output logic                frame_rdy,
    output logic [RX_CNT_W-1:0] drop_cnt,
    output logic [RX_CNT_W-1:0] ovf_cnt
);

    rx_sched_st_t          state_r, state_nx;
    logic [RX_BCNT_W-1:0]  bcnt_r;
    logic                  err_r;
    logic [AW-1:0]         last_addr_r;
    logic                  wr_en_r, wr_bank_r, frame_rdy_r;
    logic [AW-1:0]         wr_addr_r;
    logic [7:0]            wr_data_r;

    logic                  start_s, swap_s, bad_s, accept_s, reject_s;

    // a byte is unusable if the cycle is empty, the address is outside it, or the frame is full
    assign bad_s    = (din_cycle == {AW{1'b0}}) || (din_addr >= din_cycle) ||
                      (bcnt_r >= RX_BCNT_W'(MAXLEN));
    assign accept_s = (state_r == RECV) && din_vld && !bad_s;
    assign reject_s = (state_r == RECV) && din_vld && bad_s;

    // state register
    always_ff @(posedge rxclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // next-state logic and frame start / bank swap strobes
    always_comb begin
        state_nx = state_r;
        start_s  = 1'b0;
        swap_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (rxctl) begin
                    state_nx = RECV;
                    start_s  = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            RECV: begin
                if (!rxctl) begin
                    state_nx = CHECK;
                end else begin
                    state_nx = RECV;
                end
            end
            CHECK: begin
                if (err_r || (bcnt_r == {RX_BCNT_W{1'b0}})) begin
                    state_nx = IDLE;
                end else if (last_addr_r == (din_cycle - AW'(1))) begin
                    state_nx = COMMIT;
                end else begin
                    state_nx = IDLE;
                end
            end
            COMMIT: begin
                state_nx = IDLE;
                if (!frame_rdy_r || frame_ack) begin
                    swap_s = 1'b1;
                end else begin
                    swap_s = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // write port, per-frame bookkeeping, bank and ready flag
    always_ff @(posedge rxclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r     <= 1'b0;
            wr_addr_r   <= {AW{1'b0}};
            wr_data_r   <= 8'h00;
            last_addr_r <= {AW{1'b0}};
            bcnt_r      <= {RX_BCNT_W{1'b0}};
            err_r       <= 1'b0;
            wr_bank_r   <= 1'b0;
            frame_rdy_r <= 1'b0;
        end else begin
            wr_en_r <= accept_s;
            if (accept_s) begin
                wr_addr_r   <= din_addr;
                wr_data_r   <= din;
                last_addr_r <= din_addr;
            end
            if (start_s) begin
                bcnt_r <= {RX_BCNT_W{1'b0}};
                err_r  <= 1'b0;
            end else begin
                if (accept_s) begin
                    bcnt_r <= bcnt_r + RX_BCNT_W'(1);
                end
                if (reject_s) begin
                    err_r <= 1'b1;
                end
            end
            // a swap coinciding with an ack leaves the ready flag set for the new bank
            if (swap_s) begin
                wr_bank_r   <= ~wr_bank_r;
                frame_rdy_r <= 1'b1;
            end else if (frame_ack) begin
                frame_rdy_r <= 1'b0;
            end
        end
    end

`ifdef RX_FRAME_SCHED_STAT_EN
    logic drop_s, ovf_s;

    assign drop_s = (state_r == CHECK) && (err_r || (bcnt_r == {RX_BCNT_W{1'b0}}));
    assign ovf_s  = (state_r == COMMIT) && frame_rdy_r && !frame_ack;

    rx_sat_cnt #(.W(RX_CNT_W)) u_drop_cnt (
        .rxclk (rxclk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (drop_s),
        .cnt   (drop_cnt)
    );

    rx_sat_cnt #(.W(RX_CNT_W)) u_ovf_cnt (
        .rxclk (rxclk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (ovf_s),
        .cnt   (ovf_cnt)
    );
`else
    assign drop_cnt = {RX_CNT_W{1'b0}};
    assign ovf_cnt  = {RX_CNT_W{1'b0}};
`endif

    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign wr_bank   = wr_bank_r;
    assign rd_bank   = ~wr_bank_r;
    assign frame_rdy = frame_rdy_r;

endmodule

// File: tb/tb_rx_frame_sched.sv
// Directed self-checking bench for rx_frame_sched.
module tb_rx_frame_sched;

`ifdef RX_FRAME_SCHED_STAT_EN
    localparam int STAT = 1;
`else
    localparam int STAT = 0;
`endif

    logic        rxclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxctl = 1'b0;
    logic        din_vld = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [13:0] din_addr = 14'd0;
    logic [13:0] din_cycle = 14'd0;
    logic        frame_ack = 1'b0;
    logic        wr_en, wr_bank, rd_bank, frame_rdy;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] drop_cnt, ovf_cnt;

    int vecs = 0;
    int errs = 0;
    int wcount = 0;
    logic [7:0] mem [0:1][0:2047];
    logic        first_en;
    logic [13:0] first_addr;
    logic [7:0]  first_data;

    rx_frame_sched dut (
        .rxclk(rxclk), .rst_n(rst_n), .rxctl(rxctl), .din_vld(din_vld), .din(din),
        .din_addr(din_addr), .din_cycle(din_cycle), .frame_ack(frame_ack),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_bank(rd_bank), .frame_rdy(frame_rdy), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt)
    );

    always #5 rxclk = ~rxclk;

    // RAM model: capture every write strobe into the bank it targets
    always @(negedge rxclk) begin
        if (rst_n && (wr_en === 1'b1)) begin
            wcount = wcount + 1;
            if (wr_addr < 14'd2048) mem[wr_bank][wr_addr[10:0]] = wr_data;
        end
    end

    function automatic logic [7:0] pat(input int a, input int salt);
        return 8'((a * 7) + salt);
    endfunction

    task automatic step;
        @(posedge rxclk);
        #1;
    endtask

    // one frame: raise rxctl, n bytes at addr a0.., drop rxctl; returns after the edge that sees rxctl low
    task automatic send_frame(input int cyc, input int a0, input int n, input int salt);
        din_cycle = 14'(cyc);
        rxctl = 1'b1;
        step;
        for (int i = 0; i < n; i++) begin
            din_vld  = 1'b1;
            din_addr = 14'(a0 + i);
            din      = pat(a0 + i, salt);
            step;
            if (i == 0) begin
                first_en = wr_en; first_addr = wr_addr; first_data = wr_data;
            end
        end
        din_vld = 1'b0;
        rxctl = 1'b0;
        step;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step; step;
        vecs++; if (wr_en !== 1'b0) begin errs++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        vecs++; if (wr_bank !== 1'b0) begin errs++; $display("FAIL reset_wr_bank: got %b want 0", wr_bank); end
        vecs++; if (rd_bank !== 1'b1) begin errs++; $display("FAIL reset_rd_bank: got %b want 1", rd_bank); end
        vecs++; if (wr_addr !== 14'd0) begin errs++; $display("FAIL reset_wr_addr: got %0h want 0", wr_addr); end
        vecs++; if (wr_data !== 8'h00) begin errs++; $display("FAIL reset_wr_data: got %0h want 0", wr_data); end
        vecs++; if (frame_rdy !== 1'b0) begin errs++; $display("FAIL reset_frame_rdy: got %b want 0", frame_rdy); end
        vecs++; if (drop_cnt !== 16'd0 || ovf_cnt !== 16'd0) begin
            errs++; $display("FAIL reset_counters: got %0d/%0d want 0/0", drop_cnt, ovf_cnt); end
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_good_frame;
        int w0;
        w0 = wcount;
        send_frame(8, 0, 8, 1);
        vecs++; if (first_en !== 1'b1 || first_addr !== 14'd0 || first_data !== pat(0, 1)) begin
            errs++; $display("FAIL good_latency: got en=%b addr=%0d data=%0h want 1/0/%0h",
                             first_en, first_addr, first_data, pat(0, 1)); end
        vecs++; if (wr_bank !== 1'b0 || frame_rdy !== 1'b0) begin
            errs++; $display("FAIL good_check_cycle: got bank=%b rdy=%b want 0/0", wr_bank, frame_rdy); end
        step;
        vecs++; if (wr_bank !== 1'b0 || frame_rdy !== 1'b0) begin
            errs++; $display("FAIL good_commit_cycle: got bank=%b rdy=%b want 0/0", wr_bank, frame_rdy); end
        step;
        vecs++; if (wr_bank !== 1'b1 || rd_bank !== 1'b0 || frame_rdy !== 1'b1) begin
            errs++; $display("FAIL good_swap: got bank=%b rd=%b rdy=%b want 1/0/1", wr_bank, rd_bank, frame_rdy); end
        vecs++; if (wcount - w0 != 8) begin errs++; $display("FAIL good_wcount: got %0d want 8", wcount - w0); end
        for (int a = 0; a < 8; a++) begin
            vecs++; if (mem[0][a] !== pat(a, 1)) begin
                errs++; $display("FAIL good_mem[%0d]: got %0h want %0h", a, mem[0][a], pat(a, 1)); end
        end
        frame_ack = 1'b1; step; frame_ack = 1'b0;
        vecs++; if (frame_rdy !== 1'b0) begin errs++; $display("FAIL good_ack: got %b want 0", frame_rdy); end
    endtask

    task automatic test_split_cycle;
        send_frame(8, 0, 4, 2); step; step;
        vecs++; if (wr_bank !== 1'b1 || frame_rdy !== 1'b0) begin
            errs++; $display("FAIL split_first: got bank=%b rdy=%b want 1/0", wr_bank, frame_rdy); end
        send_frame(8, 4, 4, 2); step; step;
        vecs++; if (wr_bank !== 1'b0 || frame_rdy !== 1'b1) begin
            errs++; $display("FAIL split_second: got bank=%b rdy=%b want 0/1", wr_bank, frame_rdy); end
        for (int a = 0; a < 8; a++) begin
            vecs++; if (mem[1][a] !== pat(a, 2)) begin
                errs++; $display("FAIL split_mem[%0d]: got %0h want %0h", a, mem[1][a], pat(a, 2)); end
        end
        vecs++; if (drop_cnt !== 16'd0) begin errs++; $display("FAIL split_drop: got %0d want 0", drop_cnt); end
        frame_ack = 1'b1; step; frame_ack = 1'b0;
        vecs++; if (frame_rdy !== 1'b0) begin errs++; $display("FAIL split_ack: got %b want 0", frame_rdy); end
    endtask

    task automatic test_out_of_range;
        int w0;
        w0 = wcount;
        send_frame(4, 3, 2, 3); step; step;
        vecs++; if (wcount - w0 != 1) begin errs++; $display("FAIL oor_wcount: got %0d want 1", wcount - w0); end
        vecs++; if (mem[0][3] !== pat(3, 3)) begin
            errs++; $display("FAIL oor_mem3: got %0h want %0h", mem[0][3], pat(3, 3)); end
        vecs++; if (drop_cnt !== 16'(1 * STAT)) begin
            errs++; $display("FAIL oor_drop: got %0d want %0d", drop_cnt, 1 * STAT); end
        vecs++; if (wr_bank !== 1'b0 || frame_rdy !== 1'b0) begin
            errs++; $display("FAIL oor_noswap: got bank=%b rdy=%b want 0/0", wr_bank, frame_rdy); end
    endtask

    task automatic test_oversize;
        int w0;
        w0 = wcount;
        send_frame(2000, 0, 1501, 4); step; step;
        vecs++; if (wcount - w0 != 1500) begin errs++; $display("FAIL ovs_wcount: got %0d want 1500", wcount - w0); end
        vecs++; if (mem[0][0] !== pat(0, 4) || mem[0][1499] !== pat(1499, 4)) begin
            errs++; $display("FAIL ovs_mem: got %0h/%0h want %0h/%0h", mem[0][0], mem[0][1499],
                             pat(0, 4), pat(1499, 4)); end
        vecs++; if (drop_cnt !== 16'(2 * STAT)) begin
            errs++; $display("FAIL ovs_drop: got %0d want %0d", drop_cnt, 2 * STAT); end
        vecs++; if (wr_bank !== 1'b0 || frame_rdy !== 1'b0) begin
            errs++; $display("FAIL ovs_noswap: got bank=%b rdy=%b want 0/0", wr_bank, frame_rdy); end
    endtask

    task automatic test_overflow;
        send_frame(8, 0, 8, 5); step; step;
        vecs++; if (wr_bank !== 1'b1 || frame_rdy !== 1'b1) begin
            errs++; $display("FAIL ovf_first: got bank=%b rdy=%b want 1/1", wr_bank, frame_rdy); end
        send_frame(8, 0, 8, 6); step; step;
        vecs++; if (wr_bank !== 1'b1 || frame_rdy !== 1'b1) begin
            errs++; $display("FAIL ovf_second: got bank=%b rdy=%b want 1/1", wr_bank, frame_rdy); end
        vecs++; if (ovf_cnt !== 16'(1 * STAT)) begin
            errs++; $display("FAIL ovf_cnt: got %0d want %0d", ovf_cnt, 1 * STAT); end
        frame_ack = 1'b1; step; frame_ack = 1'b0;
        vecs++; if (frame_rdy !== 1'b0 || wr_bank !== 1'b1) begin
            errs++; $display("FAIL ovf_ack: got rdy=%b bank=%b want 0/1", frame_rdy, wr_bank); end
    endtask

    task automatic test_back_to_back;
        send_frame(8, 0, 8, 7); step; step;
        vecs++; if (wr_bank !== 1'b0 || frame_rdy !== 1'b1) begin
            errs++; $display("FAIL b2b_first: got bank=%b rdy=%b want 0/1", wr_bank, frame_rdy); end
        send_frame(8, 0, 8, 8); step;
        frame_ack = 1'b1; step; frame_ack = 1'b0;
        vecs++; if (wr_bank !== 1'b1 || frame_rdy !== 1'b1) begin
            errs++; $display("FAIL b2b_ack_swap: got bank=%b rdy=%b want 1/1", wr_bank, frame_rdy); end
        vecs++; if (ovf_cnt !== 16'(1 * STAT)) begin
            errs++; $display("FAIL b2b_ovf: got %0d want %0d", ovf_cnt, 1 * STAT); end
    endtask

    task automatic test_reset_mid_frame;
        din_cycle = 14'd8;
        rxctl = 1'b1;
        step;
        for (int i = 0; i < 3; i++) begin
            din_vld = 1'b1; din_addr = 14'(i); din = pat(i, 9);
            step;
        end
        rst_n = 1'b0;
        #1;
        vecs++; if (wr_en !== 1'b0 || wr_bank !== 1'b0 || rd_bank !== 1'b1 || frame_rdy !== 1'b0) begin
            errs++; $display("FAIL midrst_ctrl: got en=%b bank=%b rd=%b rdy=%b want 0/0/1/0",
                             wr_en, wr_bank, rd_bank, frame_rdy); end
        vecs++; if (wr_addr !== 14'd0 || wr_data !== 8'h00 || drop_cnt !== 16'd0 || ovf_cnt !== 16'd0) begin
            errs++; $display("FAIL midrst_data: got addr=%0d data=%0h drop=%0d ovf=%0d want 0/0/0/0",
                             wr_addr, wr_data, drop_cnt, ovf_cnt); end
        din_vld = 1'b0; rxctl = 1'b0;
        step;
        rst_n = 1'b1;
        step;
        send_frame(8, 0, 8, 10);
        vecs++; if (first_en !== 1'b1 || first_addr !== 14'd0) begin
            errs++; $display("FAIL midrst_first: got en=%b addr=%0d want 1/0", first_en, first_addr); end
        step; step;
        for (int a = 0; a < 8; a++) begin
            vecs++; if (mem[0][a] !== pat(a, 10)) begin
                errs++; $display("FAIL midrst_mem[%0d]: got %0h want %0h", a, mem[0][a], pat(a, 10)); end
        end
        vecs++; if (wr_bank !== 1'b1 || frame_rdy !== 1'b1 || drop_cnt !== 16'd0) begin
            errs++; $display("FAIL midrst_swap: got bank=%b rdy=%b drop=%0d want 1/1/0",
                             wr_bank, frame_rdy, drop_cnt); end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_split_cycle;
        test_out_of_range;
        test_oversize;
        test_overflow;
        test_back_to_back;
        test_reset_mid_frame;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
